masked_subbytes_sequencer: RTL and testbench

- Byte-serial controller for the masked SubBytes step.
- Latches a d-share 128-bit AES state and streams its 16 bytes, one per cycle, into the pipelined DOM S-box (aes_sbox_dom).
- Captures the 16 S-box results after a fixed pipeline latency and presents the substituted shared state with a one-cycle done pulse.
- Sits between the round-state register and aes_sbox_dom. Shares are never recombined.

---
 rtl/masked_aes_pkg.sv | 30 +++
 rtl/masked_subbytes_sequencer_if.sv | 20 ++
 rtl/share_byte_remap.sv | 23 ++
 rtl/masked_subbytes_sequencer.sv | 99 +++++++++
 tb/tb_masked_subbytes_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/masked_aes_pkg.sv
// Shared constants, FSM state encoding and share-layout index helpers for the masked AES datapath.
package masked_aes_pkg;

    localparam int N_BYTES          = 16;
    localparam int BYTE_W           = 8;
    localparam int DEFAULT_SBOX_LAT = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = S_IDLE,
        ST_FEED  = S_FEED,
        ST_DRAIN = S_DRAIN,
        ST_DONE  = S_DONE
    } fsm_state_e;

    // Bit b of share sh inside one byte: share-major packs shares side by side,
    // interleaved places the shares of each bit next to each other.
    function automatic int sm_idx(input int sh, input int b);
        return sh * BYTE_W + b;
    endfunction

    function automatic int il_idx(input int nsh, input int sh, input int b);
        return b * nsh + sh;
    endfunction

endpackage

// File: rtl/masked_subbytes_sequencer_if.sv
// Handshake and data bundle between the round logic, the SubBytes sequencer and the DOM S-box.
interface masked_subbytes_sequencer_if #(parameter int d = 2);
    logic               start;
    logic [128*d-1:0]   state_in;
    logic [8*d-1:0]     sbox_in;
    logic [8*d-1:0]     sbox_out;
    logic [128*d-1:0]   state_out;
    logic               busy;
    logic               done;

    modport master (
        output start, state_in, sbox_out,
        input  sbox_in, state_out, busy, done
    );

    modport slave (
        input  start, state_in, sbox_out,
        output sbox_in, state_out, busy, done
    );
endinterface

// File: rtl/share_byte_remap.sv
// Converts one shared byte between share-major and bit-interleaved layouts.
// Purely combinational wiring, zero latency, no flow control.
module share_byte_remap
    import masked_aes_pkg::*;
#(
    parameter int d     = 2,
    parameter bit TO_IL = 1'b1
) (
    input  logic [BYTE_W*d-1:0] din,
    output logic [BYTE_W*d-1:0] dout
);

    for (genvar i = 0; i < d; i++) begin : g_share
        for (genvar j = 0; j < BYTE_W; j++) begin : g_bit
            if (TO_IL) begin : g_fwd
                assign dout[il_idx(d, i, j)] = din[sm_idx(i, j)];
            end else begin : g_inv
                assign dout[sm_idx(i, j)] = din[il_idx(d, i, j)];
            end
        end
    end

endmodule

// File: rtl/masked_subbytes_sequencer.sv
// Streams a latched d-share AES state byte-serially through the DOM S-box and reassembles the result.
// Done at cycle 17+SBOX_LAT after start; start is ignored (not queued) while busy or done.
module masked_subbytes_sequencer
    import masked_aes_pkg::*;
#(
    parameter int d        = 2,
    parameter int SBOX_LAT = DEFAULT_SBOX_LAT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    masked_subbytes_sequencer_if.slave  bus
);

    localparam int SW = N_BYTES * BYTE_W;
    localparam int BW = BYTE_W * d;

    fsm_state_e             st;
    logic [SW*d-1:0]        state_q;
    logic [SW*d-1:0]        out_q;
    logic [3:0]             feed_cnt;
    logic [4:0]             cap_cnt;
    logic [SBOX_LAT-1:0]    vld_sr;
    logic [BW-1:0]          feed_sm;
    logic [BW-1:0]          feed_il;
    logic [BW-1:0]          cap_sm;
    logic                   cap_en;

    always_comb begin
        feed_sm = '0;
        for (int i = 0; i < d; i++) begin
            feed_sm[i*BYTE_W +: BYTE_W] = state_q[i*SW + BYTE_W*int'(feed_cnt) +: BYTE_W];
        end
    end

    share_byte_remap #(.d(d), .TO_IL(1'b1)) u_feed_remap (
        .din  (feed_sm),
        .dout (feed_il)
    );

    share_byte_remap #(.d(d), .TO_IL(1'b0)) u_cap_remap (
        .din  (bus.sbox_out),
        .dout (cap_sm)
    );

    // Outside FEED the S-box sees zeros so no stale shares leak into its pipeline.
    assign bus.sbox_in   = (st == ST_FEED) ? feed_il : '0;
    assign bus.state_out = out_q;
    assign bus.busy      = (st == ST_FEED) || (st == ST_DRAIN);
    assign bus.done      = (st == ST_DONE);

    assign cap_en = vld_sr[SBOX_LAT-1] && (cap_cnt != 5'(N_BYTES));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            state_q  <= '0;
            out_q    <= '0;
            feed_cnt <= '0;
            cap_cnt  <= '0;
            vld_sr   <= '0;
        end else begin
            vld_sr[0] <= (st == ST_FEED);
            for (int n = 1; n < SBOX_LAT; n++) begin
                vld_sr[n] <= vld_sr[n-1];
            end

            if (cap_en) begin
                for (int i = 0; i < d; i++) begin
                    out_q[i*SW + BYTE_W*int'(cap_cnt[3:0]) +: BYTE_W] <= cap_sm[i*BYTE_W +: BYTE_W];
                end
                cap_cnt <= cap_cnt + 5'd1;
            end

            case (st)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q  <= bus.state_in;
                        feed_cnt <= '0;
                        cap_cnt  <= '0;
                        st       <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    feed_cnt <= feed_cnt + 4'd1;
                    if (feed_cnt == 4'(N_BYTES - 1)) begin
                        st <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cap_en && (cap_cnt == 5'(N_BYTES - 1))) begin
                        st <= ST_DONE;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_subbytes_sequencer.sv
// Bench for masked_subbytes_sequencer with a behavioural DOM S-box stand-in and a cycle-level reference model.
module tb_masked_subbytes_sequencer;
    import masked_aes_pkg::*;

    localparam int D      = 2;
    localparam int LAT    = 4;
    localparam int DONE_C = N_BYTES + 1 + LAT;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    masked_subbytes_sequencer_if #(.d(D)) bus();

    masked_subbytes_sequencer #(.d(D), .SBOX_LAT(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int           pass_cnt = 0;
    int           total_cnt = 0;
    bit           chk_en = 1'b0;
    logic [7:0]   sbox_t [256];
    logic [127:0] plain = '0;
    logic [15:0]  pipe [LAT];
    int           m_c = 0;
    logic [255:0] m_lat = '0;
    logic [255:0] exp_so = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else pass_cnt++;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [15:0] to_il(input logic [7:0] s0, input logic [7:0] s1);
        logic [15:0] r;
        for (int j = 0; j < 8; j++) begin
            r[2*j]   = s0[j];
            r[2*j+1] = s1[j];
        end
        return r;
    endfunction

    function automatic logic [15:0] to_sm(input logic [15:0] il);
        logic [15:0] r;
        for (int j = 0; j < 8; j++) begin
            r[j]   = il[2*j];
            r[8+j] = il[2*j+1];
        end
        return r;
    endfunction

    function automatic logic [127:0] unshare(input logic [255:0] s);
        return s[127:0] ^ s[255:128];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] p);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_t[p[8*k +: 8]];
        return r;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_t[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    end

    // S-box stand-in: recombines, substitutes, reshares with a fresh mask, LAT cycles deep.
    always @(posedge clk) begin : env
        logic [15:0] sm;
        logic [7:0]  y;
        logic [7:0]  m;
        sm = to_sm(bus.sbox_in);
        y  = sbox_t[sm[7:0] ^ sm[15:8]];
        m  = 8'($urandom);
        pipe[0] <= to_il(m, y ^ m);
        for (int n = 1; n < LAT; n++) pipe[n] <= pipe[n-1];
    end
    assign bus.sbox_out = pipe[LAT-1];

    always @(posedge clk) begin : share_drv
        logic [127:0] r;
        #1;
        r = {$urandom, $urandom, $urandom, $urandom};
        bus.state_in = {r ^ plain, r};
    end

    // Reference: m_c is the cycle number within an operation (0 = idle).
    always @(posedge clk) begin : model
        logic [15:0] sm;
        if (!rst_n) begin
            m_c    = 0;
            exp_so = '0;
        end else begin
            if (m_c >= LAT + 1 && m_c <= LAT + N_BYTES) begin
                sm = to_sm(bus.sbox_out);
                exp_so[8*(m_c-LAT-1) +: 8]       = sm[7:0];
                exp_so[128 + 8*(m_c-LAT-1) +: 8] = sm[15:8];
            end
            if (m_c == 0) begin
                if (bus.start) begin
                    m_c   = 1;
                    m_lat = bus.state_in;
                end
            end else if (m_c == DONE_C) begin
                m_c = 0;
            end else begin
                m_c = m_c + 1;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] es;
        if (chk_en) begin
            es = '0;
            if (m_c >= 1 && m_c <= N_BYTES)
                es = to_il(m_lat[8*(m_c-1) +: 8], m_lat[128 + 8*(m_c-1) +: 8]);
            chk("busy", bus.busy, (m_c >= 1 && m_c < DONE_C));
            chk("done", bus.done, (m_c == DONE_C));
            chk("sbox_in", bus.sbox_in, es);
            chk("state_out", bus.state_out, exp_so);
        end
    end

    task automatic run_op(input logic [127:0] p, input string nm, output logic [255:0] so);
        int c;
        plain = p;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 1;
        while (!bus.done && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_done_cycle"}, c, DONE_C);
        so = bus.state_out;
        chk({nm, "_result"}, unshare(so), sub_bytes(p));
    endtask

    initial begin
        logic [255:0] so;
        logic [255:0] res1;
        logic [255:0] res2;
        logic [127:0] pa;
        logic [127:0] pb;
        int d1;
        int d2;
        int nd;

        bus.start = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_sbox_in", bus.sbox_in, 0);
        chk("rst_state_out", bus.state_out, 0);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        run_op(128'h0, "zero", so);
        chk("zero_lit", unshare(so), {16{8'h63}});

        run_op(128'h0F0E0D0C0B0A09080706050403020100, "incr", so);
        chk("incr_lit", unshare(so), 128'h76ABD7FE2B670130C56F6BF27B777C63);

        run_op({16{8'h53}}, "x53", so);
        chk("x53_lit", unshare(so), {16{8'hED}});
        chk("x53_share_sep", (so[127:0] != unshare(so)) && (so[127:0] != 128'h0), 1);

        pa = 128'h00112233445566778899AABBCCDDEEFF;
        pb = 128'h3243F6A8885A308D313198A2E0370734;
        plain = pa;
        d1 = 0; d2 = 0; nd = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (bus.done) begin
                nd++;
                if (d1 == 0) begin
                    d1   = c;
                    res1 = bus.state_out;
                end else begin
                    d2   = c;
                    res2 = bus.state_out;
                end
            end
            bus.start = (c == 5 || c == 21 || c == 22);
            if (c == 20) plain = pb;
        end
        bus.start = 1'b0;
        chk("b2b_first_done", d1, DONE_C);
        chk("b2b_second_done", d2, 22 + DONE_C);
        chk("b2b_done_count", nd, 2);
        chk("b2b_first_result", unshare(res1), sub_bytes(pa));
        chk("b2b_second_result", unshare(res2), sub_bytes(pb));

        plain = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 2; c <= 10; c++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_sbox_in", bus.sbox_in, 0);
        chk("midrst_state_out", bus.state_out, 0);
        rst_n = 1'b1;
        repeat (LAT) @(negedge clk);
        run_op(128'hA5A5A5A5_5A5A5A5A_01020408_10204080, "after_rst", so);

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_sbox_in", bus.sbox_in, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
